// File: rtl/sclk_generator.sv
// Serial clock burst generator: emits i_num full o_sclk cycles of half-period
// i_div (clamped to DIV_MIN) with idle level i_cpol, plus edge and done strobes.
module sclk_generator #(
    parameter int CNT_W   = 16,
    parameter int NUM_W   = 8,
    parameter int DIV_MIN = 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [CNT_W-1:0] i_div,
    input  logic             i_cpol,
    input  logic [NUM_W-1:0] i_num,
    input  logic             i_start,
    input  logic             i_pause,
    output logic             o_sclk,
    output logic             o_lead,
    output logic             o_trail,
    output logic             o_busy,
    output logic             o_done
);

    localparam logic [CNT_W-1:0] DIV_MIN_C = CNT_W'(DIV_MIN);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] div_l;
    logic [NUM_W-1:0] num_l;
    logic             cpol_l;
    logic [CNT_W-1:0] half_cnt;
    logic [NUM_W-1:0] trail_cnt;

    always_ff @(posedge i_clk) begin
        // NOTE: strobes default low every edge and are raised only on the edge
        // that produces them, so each lasts exactly one cycle.
        o_lead  <= 1'b0;
        o_trail <= 1'b0;
        o_done  <= 1'b0;

        if (!i_rst_n) begin
            state     <= IDLE;
            o_sclk    <= 1'b0;
            o_busy    <= 1'b0;
            div_l     <= DIV_MIN_C;
            num_l     <= '0;
            cpol_l    <= 1'b0;
            half_cnt  <= '0;
            trail_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    o_sclk <= i_cpol;
                    if (i_start && (i_num != '0)) begin
                        div_l     <= (i_div < DIV_MIN_C) ? DIV_MIN_C : i_div;
                        num_l     <= i_num;
                        cpol_l    <= i_cpol;
                        half_cnt  <= '0;
                        trail_cnt <= '0;
                        o_busy    <= 1'b1;
                        state     <= RUN;
                    end
                end

                RUN: begin
                    if (!i_pause) begin
                        if (half_cnt == div_l - 1'b1) begin
                            half_cnt <= '0;
                            o_sclk   <= ~o_sclk;
                            if (o_sclk == cpol_l) begin
                                o_lead <= 1'b1;
                            end else begin
                                o_trail <= 1'b1;
                                // Compare before incrementing so the counter never wraps at max i_num.
                                if (trail_cnt == num_l - 1'b1) begin
                                    o_done <= 1'b1;
                                    o_busy <= 1'b0;
                                    o_sclk <= cpol_l;
                                    state  <= IDLE;
                                end else begin
                                    trail_cnt <= trail_cnt + 1'b1;
                                end
                            end
                        end else begin
                            half_cnt <= half_cnt + 1'b1;
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
